// File: rtl/pc_resp_reader_pkg.sv
// pc_resp_reader_pkg: shared address map, response-reader constants and state encoding
package pc_resp_reader_pkg;
  localparam logic [10:0] ADDR_DEFAULT  = 11'h000;
  localparam logic [10:0] ADDR_PC_REQ   = 11'h100;
  localparam logic [10:0] DEF_RESP_BASE = 11'h200;
  localparam logic [10:0] DEF_MAX_LEN   = 11'd256;
  localparam int TCODE_LSB = 4;
  localparam int TCODE_MSB = 7;
  localparam int SRC_LSB   = 16;
  localparam int SRC_MSB   = 31;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_e;
endpackage

// File: rtl/pc_resp_reader_resp_fifo2.sv
// resp_fifo2: two-entry 32-bit buffer between memory read data and a valid/ready sink
module resp_fifo2 (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  count
);
  logic [31:0] d0_q, d1_q;
  logic [1:0]  cnt_q, slot;
  logic        pop;

  assign pop       = out_valid & out_ready;
  assign slot      = cnt_q - {1'b0, pop};
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = d0_q;
  assign count     = cnt_q;

  // head advances on pop; a new word lands in the first slot left free (writer never pushes when full)
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      d0_q  <= '0;
      d1_q  <= '0;
      cnt_q <= '0;
    end else begin
      d0_q  <= (in_valid && slot == 2'd0) ? in_data : pop ? d1_q : d0_q;
      d1_q  <= (in_valid && slot == 2'd1) ? in_data : d1_q;
      cnt_q <= slot + {1'b0, in_valid};
    end
  end
endmodule

// File: rtl/pc_resp_reader.sv
// pc_resp_reader: streams a response block from shared memory to a valid/ready sink
module pc_resp_reader
  import pc_resp_reader_pkg::*;
#(
  parameter logic [10:0] RESP_BASE = DEF_RESP_BASE,
  parameter logic [10:0] MAX_LEN   = DEF_MAX_LEN
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        req_done,
  input  logic [10:0] resp_len,
  output logic        mem_en,
  output logic [10:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [3:0]  hdr_tcode,
  output logic [15:0] hdr_src_id,
  output logic        busy,
  output logic        len_err,
  output logic        resp_valid
);
  rd_state_e   state_q, state_d;
  logic        req_q;
  logic [10:0] len_q, len_d, iss_q, iss_d, wr_q, wr_d, acc_q, acc_d;
  logic        infl_q, len_err_q, len_err_d;
  logic [3:0]  tcode_q, tcode_d;
  logic [15:0] src_q, src_d;
  logic [1:0]  occ;
  logic [2:0]  fill;
  logic        pop, start, bad_len;

  assign start      = req_done & ~req_q;
  assign bad_len    = (resp_len == 11'd0) || (resp_len > MAX_LEN);
  assign pop        = out_valid & out_ready;
  // buffer contents after this cycle's pop plus the word still returning from memory
  assign fill       = {1'b0, occ} + {2'b0, infl_q} - {2'b0, pop};
  assign mem_addr   = RESP_BASE + iss_q;
  assign busy       = state_q != IDLE;
  assign resp_valid = state_q == DONE;
  assign len_err    = len_err_q;
  assign out_last   = out_valid && (acc_q == len_q - 11'd1);
  assign hdr_tcode  = tcode_q;
  assign hdr_src_id = src_q;

  resp_fifo2 u_fifo (
    .sysclk    (sysclk),
    .reset     (reset),
    .in_data   (mem_rdata),
    .in_valid  (infl_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (occ)
  );

  // next state, read issue, word counters and header capture
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    iss_d     = iss_q;
    wr_d      = infl_q ? wr_q + 11'd1 : wr_q;
    acc_d     = pop ? acc_q + 11'd1 : acc_q;
    tcode_d   = (infl_q && wr_q == 11'd0) ? mem_rdata[TCODE_MSB:TCODE_LSB] : tcode_q;
    src_d     = (infl_q && wr_q == 11'd1) ? mem_rdata[SRC_MSB:SRC_LSB] : src_q;
    len_err_d = 1'b0;
    mem_en    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        len_d     = resp_len;
        iss_d     = '0;
        wr_d      = '0;
        acc_d     = '0;
        len_err_d = bad_len;
        state_d   = bad_len ? IDLE : READ;
      end
      READ: begin
        mem_en  = (iss_q != len_q) && (fill < 3'd2);
        iss_d   = iss_q + {10'd0, mem_en};
        state_d = (iss_q == len_q) ? DRAIN : READ;
      end
      DRAIN:   state_d = (acc_q == len_q) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset abandons any read in progress
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      len_q     <= '0;
      iss_q     <= '0;
      wr_q      <= '0;
      acc_q     <= '0;
      infl_q    <= 1'b0;
      len_err_q <= 1'b0;
      tcode_q   <= '0;
      src_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_done;
      len_q     <= len_d;
      iss_q     <= iss_d;
      wr_q      <= wr_d;
      acc_q     <= acc_d;
      infl_q    <= mem_en;
      len_err_q <= len_err_d;
      tcode_q   <= tcode_d;
      src_q     <= src_d;
    end
  end
endmodule

// File: tb/tb_pc_resp_reader.sv
// tb_pc_resp_reader: randomized self-checking bench for the response reader
module tb_pc_resp_reader;
  import pc_resp_reader_pkg::*;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic        req_done = 1'b0;
  logic [10:0] resp_len = '0;
  logic        mem_en;
  logic [10:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [3:0]  hdr_tcode;
  logic [15:0] hdr_src_id;
  logic        busy, len_err, resp_valid;

  logic        w_req_done = 1'b0;
  logic [10:0] w_resp_len = '0;
  logic        w_mem_en;
  logic [10:0] w_mem_addr;
  logic [31:0] w_mem_rdata = '0;
  logic [31:0] w_out_data;
  logic        w_out_valid, w_out_last;
  logic        w_out_ready = 1'b1;
  logic [3:0]  w_hdr_tcode;
  logic [15:0] w_hdr_src_id;
  logic        w_busy, w_len_err, w_resp_valid;

  logic [31:0] mem [2048];

  int n_chk = 0, n_err = 0;
  int cyc = 0, rmode = 0;
  int mem_idx = 0, mem_cnt = 0, rv_cnt = 0, le_cnt = 0, busy_cnt = 0;
  int t0 = 0, lat = 0, w_rv = 0, w_le = 0;
  bit seen_v = 0, stall_q = 0;
  logic [31:0] held = '0;
  logic [3:0]  tc_m = '0;
  logic [15:0] src_m = '0;
  logic [31:0] exp_q[$];
  logic [10:0] w_addr_q[$];
  logic [31:0] w_dat_q[$];

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) if (mem_en) mem_rdata <= mem[mem_addr];
  always @(posedge sysclk) if (w_mem_en) w_mem_rdata <= mem[w_mem_addr];

  pc_resp_reader dut (
    .sysclk(sysclk), .reset(reset), .req_done(req_done), .resp_len(resp_len),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .hdr_tcode(hdr_tcode), .hdr_src_id(hdr_src_id), .busy(busy), .len_err(len_err),
    .resp_valid(resp_valid)
  );

  pc_resp_reader #(.RESP_BASE(11'h7FE)) wdut (
    .sysclk(sysclk), .reset(reset), .req_done(w_req_done), .resp_len(w_resp_len),
    .mem_en(w_mem_en), .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_last(w_out_last),
    .hdr_tcode(w_hdr_tcode), .hdr_src_id(w_hdr_src_id), .busy(w_busy), .len_err(w_len_err),
    .resp_valid(w_resp_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // sink-side scoreboard, sampled on the falling edge
  task automatic monitor();
    logic [31:0] w;
    if (out_valid && stall_q) check("stable", out_data, held);
    if (out_valid) check("last", out_last, exp_q.size() == 1);
    if (out_valid && !seen_v) begin
      seen_v = 1;
      lat = cyc - t0;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_word", exp_q.size(), 1);
      else begin
        w = exp_q.pop_front();
        check("data", out_data, w);
      end
    end
    stall_q = out_valid && !out_ready;
    held = out_data;
    if (mem_en) begin
      check("addr", mem_addr, 32'(DEF_RESP_BASE) + mem_idx);
      mem_idx++;
      mem_cnt++;
    end
    if (resp_valid) rv_cnt++;
    if (len_err) le_cnt++;
    if (busy) busy_cnt++;
    if (w_mem_en) w_addr_q.push_back(w_mem_addr);
    if (w_out_valid) check("wrap_last", w_out_last, w_dat_q.size() == 3);
    if (w_out_valid && w_out_ready) w_dat_q.push_back(w_out_data);
    if (w_resp_valid) w_rv++;
    if (w_len_err) w_le++;
  endtask

  task automatic tick();
    @(negedge sysclk);
    monitor();
    @(posedge sysclk);
    #1;
    cyc++;
    out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
  endtask

  task automatic run(input int len, input int mode, input bit glitch);
    int r0, m0;
    r0 = rv_cnt;
    m0 = mem_cnt;
    rmode = mode;
    exp_q.delete();
    mem_idx = 0;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[DEF_RESP_BASE + i]);
    tc_m = mem[DEF_RESP_BASE][7:4];
    if (len > 1) src_m = mem[DEF_RESP_BASE + 1][31:16];
    resp_len = 11'(len);
    req_done = 1'b1;
    t0 = cyc;
    seen_v = 0;
    for (int i = 0; i < 3000 && rv_cnt == r0; i++) begin
      if (glitch && i == 3) req_done = 1'b0;
      if (glitch && i == 4) req_done = 1'b1;
      tick();
    end
    req_done = 1'b0;
    tick();
    tick();
    check("resp_valid_cnt", rv_cnt - r0, 1);
    check("words_left", exp_q.size(), 0);
    check("mem_en_cnt", mem_cnt - m0, len);
    check("tcode", hdr_tcode, tc_m);
    check("src_id", hdr_src_id, src_m);
    if (mode == 0) check("latency", lat, 3);
  endtask

  task automatic bad(input int len);
    int l0, m0, b0;
    l0 = le_cnt;
    m0 = mem_cnt;
    b0 = busy_cnt;
    resp_len = 11'(len);
    req_done = 1'b1;
    repeat (4) tick();
    req_done = 1'b0;
    tick();
    check("len_err_cnt", le_cnt - l0, 1);
    check("bad_mem_en", mem_cnt - m0, 0);
    check("bad_busy", busy_cnt - b0, 0);
  endtask

  initial begin
    int r0, w0, len;
    logic [10:0] a;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[11'h200] = 32'hFFC0_0010;
    mem[11'h201] = 32'hFFFF_0000;
    mem[11'h202] = 32'h0000_0003;
    mem[11'h203] = 32'h1234_5678;
    mem[11'h204] = 32'hEFC6_56FC;
    repeat (3) tick();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 11'h200);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_len_err", len_err, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_tcode", hdr_tcode, 0);
    check("rst_src_id", hdr_src_id, 0);
    check("rst_wrap_addr", w_mem_addr, 11'h7FE);
    reset = 1'b1;
    tick();
    run(5, 0, 0);
    check("ex_tcode", hdr_tcode, 4'h1);
    check("ex_src", hdr_src_id, 16'hFFFF);
    run(5, 1, 0);
    bad(0);
    bad(257);
    run(1, 0, 0);
    run(256, 0, 0);
    run(6, 0, 1);
    exp_q.delete();
    mem_idx = 0;
    rmode = 0;
    for (int i = 0; i < 5; i++) exp_q.push_back(mem[DEF_RESP_BASE + i]);
    resp_len = 11'd5;
    req_done = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 3; i++) tick();
    check("abort_point", exp_q.size(), 3);
    reset = 1'b0;
    req_done = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_tcode", hdr_tcode, 0);
    r0 = rv_cnt;
    exp_q.delete();
    reset = 1'b1;
    repeat (5) tick();
    check("abort_no_resp", rv_cnt - r0, 0);
    run(5, 0, 0);
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 48);
      for (int i = 0; i < len; i++) mem[DEF_RESP_BASE + i] = $urandom;
      run(len, 2, 0);
    end
    w_addr_q.delete();
    w_dat_q.delete();
    w0 = w_rv;
    w_resp_len = 11'd4;
    w_req_done = 1'b1;
    for (int i = 0; i < 100 && w_rv == w0; i++) tick();
    w_req_done = 1'b0;
    tick();
    check("wrap_resp_valid", w_rv - w0, 1);
    check("wrap_addr_cnt", w_addr_q.size(), 4);
    check("wrap_word_cnt", w_dat_q.size(), 4);
    for (int i = 0; i < 4 && i < w_addr_q.size() && i < w_dat_q.size(); i++) begin
      a = 11'h7FE + 11'(i);
      check("wrap_addr", w_addr_q[i], a);
      check("wrap_data", w_dat_q[i], mem[a]);
    end
    check("wrap_tcode", w_hdr_tcode, mem[11'h7FE][7:4]);
    check("wrap_src", w_hdr_src_id, mem[11'h7FF][31:16]);
    check("wrap_busy", w_busy, 0);
    check("wrap_len_err", w_le, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pc_resp_reader.md
PC_RESP_READER -- requirements
Module: pc_resp_reader

Interface
REQ-001 Parameter RESP_BASE, 11'h200, first quadlet address of the response region in the shared block memory.
REQ-002 Parameter MAX_LEN, 11'd256, largest legal response length in quadlets.
REQ-003 sysclk  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_done  in  1  level from the phy-link block; 1 means the request executed and the response is in memory.
REQ-006 resp_len  in  11  response length in quadlets, valid while req_done=1.
REQ-007 mem_en  out  1  memory read enable.
REQ-008 mem_addr  out  11  memory read address.
REQ-009 mem_rdata  in  32  memory read data, 1-cycle latency after mem_en.
REQ-010 out_data  out  32  streamed response quadlet.
REQ-011 out_valid  out  1  out_data is valid.
REQ-012 out_ready  in  1  sink accepts the word; a transfer occurs when out_valid=1 and out_ready=1.
REQ-013 out_last  out  1  marks the final quadlet; qualified by out_valid.
REQ-014 hdr_tcode  out  4  tcode latched from quadlet 0 bits [7:4].
REQ-015 hdr_src_id  out  16  source id latched from quadlet 1 bits [31:16].
REQ-016 busy  out  1  a read is in progress (state is not IDLE).
REQ-017 len_err  out  1  1-cycle pulse: illegal length.
REQ-018 resp_valid  out  1  1-cycle pulse: full response delivered.

Function
REQ-019 States: IDLE, READ, DRAIN, DONE.
REQ-020 IDLE: a req_done 0->1 edge (registered previous value) latches resp_len into len_q and clears the read/issue counters.
- If resp_len=0 or resp_len>MAX_LEN: pulse len_err the next cycle and stay in IDLE.
- Otherwise go to READ.
REQ-021 READ: issue mem_en with mem_addr=RESP_BASE+issue_cnt (11-bit, wraps modulo 2048) only when the 2-entry output buffer can hold the in-flight word, i.e. (occupancy + in-flight) < 2.
REQ-022 The returned word enters the 2-entry FIFO one cycle after issue.
- out_data/out_valid come from the FIFO head.
- Sustained throughput is 1 quadlet/cycle with out_ready=1.
- First out_valid appears 2 cycles after entering READ.
REQ-023 When issue_cnt reaches len_q, go to DRAIN; DRAIN goes to DONE when the accepted-word count equals len_q.
REQ-024 out_last=1 exactly when the head word is accepted-word index len_q-1.
REQ-025 hdr_tcode is loaded when word index 0 enters the FIFO; hdr_src_id is loaded when index 1 enters. Both hold until the next read; for len_q=1, hdr_src_id keeps its previous value.
REQ-026 DONE: resp_valid=1 for one cycle, then IDLE.
REQ-027 req_done edges while busy=1 are ignored; req_done falling mid-read does not abort the read.
REQ-028 out_valid, once asserted, holds with stable out_data until accepted; backpressure never drops or duplicates a word.
REQ-029 Words are delivered in address order; no word beyond len_q is ever read.

Reset
REQ-030 Reset mid-read aborts immediately; no resp_valid follows.
REQ-031 Reset values:
- state=IDLE
- mem_en, out_valid, out_last, busy, len_err, resp_valid = 0
- mem_addr=RESP_BASE
- out_data, hdr_tcode, hdr_src_id = 0
- FIFO empty
- previous req_done register = 0

Structure
REQ-032 The shared constants package holds RESP_BASE, MAX_LEN, the state encodings, and the tcode bit positions, alongside the existing ADDR_DEFAULT/ADDR_PC_REQ definitions.
REQ-033 One sub-module, resp_fifo2 (2-entry, 32-bit, valid/ready), holds the output buffer; everything else is a single FSM.

Verification
REQ-034 Memory 0x200..0x204 = FFC0_0010, FFFF_0000, 0000_0003, 1234_5678, EFC6_56FC; resp_len=5; req_done rises; out_ready=1 -> five words in order, out_last on EFC6_56FC, hdr_tcode=1, hdr_src_id=FFFF, resp_valid 1 cycle later.
REQ-035 Same data with out_ready toggling 1,0,0,1,... -> identical sequence, no loss or duplication, out_data stable while stalled.
REQ-036 resp_len=0, then resp_len=257 -> len_err pulse each time, no mem_en, busy stays 0.
REQ-037 RESP_BASE=11'h7FE, resp_len=4 -> addresses 7FE, 7FF, 000, 001.
REQ-038 Reset asserted after 2 words, then released, then req_done re-raised -> clean restart from word 0, no resp_valid from the aborted read.
REQ-039 Second req_done edge during READ -> ignored; exactly len_q words, one resp_valid.
